// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter/rotator: one log2 stage per register slot, valid/ready
// handshake with a combinational ready chain, sideband tag and illegal-op flag per operation.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam logic [2:0] OpSll = 3'b000;
    localparam logic [2:0] OpSrl = 3'b001;
    localparam logic [2:0] OpSra = 3'b010;
    localparam logic [2:0] OpRol = 3'b011;
    localparam logic [2:0] OpRor = 3'b100;

    logic [SHAMT_W-1:0]                valid_q, valid_d;
    logic [SHAMT_W-1:0][WIDTH-1:0]     data_q, data_d;
    logic [SHAMT_W-1:0][SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [SHAMT_W-1:0][2:0]           op_q, op_d;
    logic [SHAMT_W-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [SHAMT_W-1:0]                err_q, err_d;

    // Stage inputs: slot 0 takes the upstream port, slot k takes slot k-1.
    logic [SHAMT_W-1:0]                src_valid;
    logic [SHAMT_W-1:0][WIDTH-1:0]     src_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0]   src_shamt;
    logic [SHAMT_W-1:0][2:0]           src_op;
    logic [SHAMT_W-1:0][TAG_W-1:0]     src_tag;
    logic [SHAMT_W-1:0]                src_err;
    logic [SHAMT_W-1:0]                ready;

    assign src_valid = {valid_q[SHAMT_W-2:0], in_valid};
    assign src_data  = {data_q[SHAMT_W-2:0], in_data};
    assign src_shamt = {shamt_q[SHAMT_W-2:0], in_shamt};
    assign src_op    = {op_q[SHAMT_W-2:0], in_op};
    assign src_tag   = {tag_q[SHAMT_W-2:0], in_tag};
    assign src_err   = {err_q[SHAMT_W-2:0], (in_op > OpRor)};

    function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] x,
                                                  input logic [2:0]       op,
                                                  input logic             en,
                                                  input int unsigned      d);
        stage_fn = x;
        if (en) begin
            case (op)
                OpSll:   stage_fn = x << d;
                OpSrl:   stage_fn = x >> d;
                OpSra:   stage_fn = $signed(x) >>> d;
                OpRol:   stage_fn = (x << d) | (x >> (WIDTH - d));
                OpRor:   stage_fn = (x >> d) | (x << (WIDTH - d));
                default: stage_fn = x;
            endcase
        end
    endfunction

    // Slot k can load unless it and every slot after it are full while out_ready is low.
    always_comb begin
        logic full;
        full  = 1'b1;
        ready = '0;
        for (int k = int'(SHAMT_W) - 1; k >= 0; k--) begin
            full     = full & valid_q[k];
            ready[k] = ~full | out_ready;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        err_d   = err_q;
        for (int k = 0; k < int'(SHAMT_W); k++) begin
            if (ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k]  = stage_fn(src_data[k], src_op[k],
                                          src_shamt[k][SHAMT_W-1-k], WIDTH >> (k + 1));
                    shamt_d[k] = src_shamt[k];
                    op_d[k]    = src_op[k];
                    tag_d[k]   = src_tag[k];
                    err_d[k]   = src_err[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = ready[0] & ~rst;
    assign out_valid = valid_q[SHAMT_W-1];
    assign out_data  = data_q[SHAMT_W-1];
    assign out_tag   = tag_q[SHAMT_W-1];
    assign out_err   = err_q[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed cases plus randomized traffic against a whole-shift reference
// model and an in-order scoreboard; a second WIDTH=8 instance covers the narrow build.
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic [3:0]  in_tag, out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt, b_in_op;
    logic [3:0]  b_in_tag, b_out_tag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    int   log_tag[$];
    int   log_cyc[$];

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_err(out_err)
    );

    pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Whole-amount reference: the full shift applied at once, rotates via a doubled word.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] s,
                                          input logic [2:0] op);
        logic [63:0] dbl;
        dbl = {x, x};
        case (op)
            3'd0: model = x << s;
            3'd1: model = x >> s;
            3'd2: model = $signed(x) >>> s;
            3'd3: begin dbl = dbl << s; model = dbl[63:32]; end
            3'd4: begin dbl = dbl >> s; model = dbl[31:0]; end
            default: model = x;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("out_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_result", {out_err, out_tag, out_data}, {e.err, e.tag, e.data});
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd5);
                    log_tag.push_back(int'(out_tag));
                    log_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.data = model(in_data, in_shamt, in_op);
                e.tag  = in_tag;
                e.err  = (in_op > 3'd4);
                e.cyc  = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                        input logic [3:0] tag);
        int n;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; in_tag = tag;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                           input logic [31:0] exp, input logic exp_err, input string name);
        int n;
        send(d, s, op, 4'h5);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_data"}, {out_err, out_data}, {exp_err, exp});
        chk({name, "_lat"}, 64'(n), 64'd4);
    endtask

    task automatic wait_log(input int cnt);
        int n;
        n = 0;
        while (log_tag.size() < cnt && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int acc;
        int n;
        logic [31:0] hd;
        logic [3:0]  ht;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out", {out_valid, out_err, out_tag, out_data}, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed single operations with latency checks.
        lat_chk = 1'b1;
        run_one(32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b0, "sll31");
        run_one(32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001, 1'b0, "srl31");
        run_one(32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000, 1'b0, "sra_neg");
        run_one(32'h4000_0000, 5'd4,  3'd2, 32'h0400_0000, 1'b0, "sra_pos");
        run_one(32'h8000_0001, 5'd1,  3'd3, 32'h0000_0003, 1'b0, "rol1");
        run_one(32'h0000_0001, 5'd1,  3'd4, 32'h8000_0000, 1'b0, "ror1");
        run_one(32'h1234_5678, 5'd3,  3'd7, 32'h1234_5678, 1'b1, "illegal");
        run_one(32'hCAFE_F00D, 5'd0,  3'd4, 32'hCAFE_F00D, 1'b0, "ror0");
        repeat (2) @(posedge clk);

        // Back-to-back streaming: tags 0..7 on consecutive cycles.
        #1;
        log_tag.delete(); log_cyc.delete();
        for (int i = 0; i < 8; i++) send($urandom, 5'($urandom), 3'($urandom_range(0, 4)), 4'(i));
        wait_log(8);
        chk("stream_count", 64'(log_tag.size()), 64'd8);
        for (int i = 0; i < log_tag.size(); i++) begin
            chk("stream_tag", 64'(log_tag[i]), 64'(i));
            chk("stream_gap", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
        end

        // Backpressure: out_ready low for 10 cycles while upstream keeps offering.
        lat_chk = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        log_tag.delete(); log_cyc.delete();
        acc = 0; hd = '0; ht = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom);
            in_op = 3'($urandom_range(0, 4)); in_tag = 4'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            if (c == 6) begin hd = out_data; ht = out_tag; end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_accepted", 64'(acc), 64'd5);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", {out_tag, out_data}, {ht, hd});
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_log(5);
        repeat (10) @(negedge clk);
        chk("drain_count", 64'(log_tag.size()), 64'd5);
        for (int i = 0; i < log_tag.size(); i++) chk("drain_tag", 64'(log_tag[i]), 64'(i));
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with three operations in flight.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send($urandom, 5'($urandom), 3'd0, 4'(i + 8));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        log_tag.delete(); log_cyc.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_stale", 64'(log_tag.size()), 64'd0);

        // Randomized traffic with random backpressure, all op codes.
        @(posedge clk);
        for (int c = 0; c < 400; c++) begin
            #1;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom; in_shamt = 5'($urandom); in_op = 3'($urandom);
            in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
        end
        #1 in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("random_drained", 64'(sb.size()), 64'd0);

        // WIDTH=8 build: latency 3.
        @(posedge clk);
        #1 b_in_valid = 1'b1; b_in_data = 8'h81; b_in_shamt = 3'd3; b_in_op = 3'd3;
        @(posedge clk);
        #1 b_in_data = 8'h90; b_in_shamt = 3'd2; b_in_op = 3'd2;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("w8_rol", {b_out_err, b_out_data}, {1'b0, 8'h0C});
        chk("w8_lat", 64'(n), 64'd1);
        @(negedge clk);
        chk("w8_sra", {b_out_valid, b_out_data}, {1'b1, 8'hE4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter/rotator for the datapath, generalising the existing 32-bit combinational shifter.
- Adds arbitrary power-of-two width, rotate modes, per-stage pipeline registers, a valid/ready handshake with backpressure, and a sideband tag that travels with each operation.
- Sits between the ALU issue logic and writeback, in place of the combinational shifter wherever timing demands it.

Parameters:
WIDTH, 32, data width; power of two, minimum 4.
SHAMT_W, $clog2(WIDTH), shift-amount width (derived, not overridden).
TAG_W, 4, width of sideband tag carried alongside data.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream operation valid
in_ready  output  1  block can accept an operation this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift/rotate amount
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_tag  output  TAG_W  tag of the operation producing out_data
out_err  output  1  operation carried an illegal op code

Behaviour:
- Single clock domain, clk.
- Reset is synchronous and active-high on rst; no asynchronous reset anywhere.
- Pipeline structure:
  - SHAMT_W stages. Stage k (k=0 first) applies distance WIDTH>>(k+1) when shamt bit SHAMT_W-1-k is set, otherwise passes data unchanged.
  - Each stage ends in a register slot holding: valid, data, remaining shamt, op, tag, err.
  - out_* is driven directly from the last slot.
- Latency: exactly SHAMT_W cycles from in_valid&&in_ready to out_valid, given no stall (5 for WIDTH=32).
- Throughput: one operation per cycle.
- Handshake:
  - A transfer occurs when valid&&ready are both high on a rising edge.
  - Slot k loads from its predecessor when slot k is empty or slot k is draining this cycle (downstream accepts it).
  - in_ready = slot 0 loadable. The ready chain is combinational back from out_ready; no bubbles are inserted.
  - When out_valid=1 and out_ready=0, out_data, out_tag and out_err hold stable until accepted.
  - in_valid may be asserted while in_ready=0; that operation is not captured.
- Fill and wrap rules per stage at distance D:
  - SLL: zeros enter at the LSBs.
  - SRL: zeros enter at the MSBs.
  - SRA: the stage's input MSB enters at the MSBs. Cascading this preserves the sign.
  - ROL/ROR: bits shifted out re-enter at the opposite end (wrap-around modulo WIDTH).
- shamt=0: data passes unchanged for every op, with the same latency.
- Illegal op: data passes unchanged, out_err=1 with the result. The op is not dropped.
- Reset values (all slots cleared): out_valid=0, out_data=0, out_tag=0, out_err=0; in_ready=1 in the cycle after rst deasserts.
- rst asserted mid-operation: all in-flight operations are discarded, with no partial output. in_ready=0 while rst=1.
- Simultaneous load and drain of the same slot in one cycle: the slot is replaced with the new entry and stays valid.

Test Plan:
- WIDTH=32; SLL 0x00000001 shamt 31 -> out_data 0x80000000 exactly 5 cycles after acceptance; SRL 0x80000000 shamt 31 -> 0x00000001.
- SRA 0x80000000 shamt 4 -> 0xF8000000; SRA 0x40000000 shamt 4 -> 0x04000000; ROL 0x80000001 shamt 1 -> 0x00000003; ROR 0x00000001 shamt 1 -> 0x80000000.
- Back-to-back streaming of 8 ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles; tags appear in order with no gaps.
- Hold out_ready=0 for 10 cycles while streaming:
  - in_ready falls after 5 accepted ops.
  - out_data/out_tag stay stable.
  - Releasing out_ready drains all 5 in order with none lost or duplicated.
- in_op=111, data 0x12345678, shamt 3 -> out_data 0x12345678, out_err=1; shamt 0 with op ROR -> data unchanged, out_err=0.
- Assert rst for 1 cycle with 3 ops in flight:
  - out_valid=0 the next cycle and no stale results emerge.
  - in_ready=1 once rst deasserts.
  - WIDTH=8 build: ROL 0x81 shamt 3 -> 0x0C.
